// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default geometry, register index type and
// the hardwired-zero register index, used by the regfile and decode/hazard logic.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_bypass.sv
// Per-read-port result selection: zero register, same-cycle writeback forwarding
// (highest write port wins) or stored data, plus the hazard-visible busy flag.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int AW     = AW_DEF,
  parameter int NWRITE = 1
) (
  input  logic [AW-1:0]          raddr_i,
  input  logic [NWRITE-1:0]      we_i,
  input  logic [NWRITE*AW-1:0]   waddr_i,
  input  logic [NWRITE*XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0]        stored_i,
  input  logic                   busy_i,
  output logic [XLEN-1:0]        rdata_o,
  output logic                   rbusy_o
);

  logic            hit;
  logic [XLEN-1:0] byp_data;

  always_comb begin
    hit      = 1'b0;
    byp_data = '0;
    // Ascending scan: a later (higher-index) matching port overrides earlier ones.
    for (int k = 0; k < NWRITE; k++) begin
      if (we_i[k] && (waddr_i[k*AW +: AW] == raddr_i)) begin
        hit      = 1'b1;
        byp_data = wdata_i[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rdata_o = stored_i;
    rbusy_o = busy_i;
    if (raddr_i == '0) begin
      rdata_o = '0;
      rbusy_o = 1'b0;
    end else if (hit) begin
      rdata_o = byp_data;
      rbusy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write-to-read bypass and a per-register
// busy scoreboard whose population count is tracked incrementally.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int NREAD  = 2,
  parameter  int NWRITE = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NWRITE-1:0]      we_i,
  input  logic [NWRITE*AW-1:0]   waddr_i,
  input  logic [NWRITE*XLEN-1:0] wdata_i,
  input  logic [NREAD*AW-1:0]    raddr_i,
  output logic [NREAD*XLEN-1:0]  rdata_o,
  output logic [NREAD-1:0]       rbusy_o,
  input  logic                   issue_valid_i,
  input  logic [AW-1:0]          issue_rd_i,
  input  logic                   flush_i,
  output logic [AW:0]            busy_cnt_o
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] set_vec, clr_vec;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;
  logic [AW:0]      dec_cnt;
  logic             inc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NWRITE; k++) begin
        if (we_i[k] && (waddr_i[k*AW +: AW] != '0)) begin
          regs_q[waddr_i[k*AW +: AW]] <= wdata_i[k*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    for (int k = 0; k < NWRITE; k++) begin
      if (we_i[k] && (waddr_i[k*AW +: AW] != '0)) begin
        clr_vec[waddr_i[k*AW +: AW]] = 1'b1;
      end
    end
    if (issue_valid_i && !flush_i && (issue_rd_i != '0)) begin
      set_vec[issue_rd_i] = 1'b1;
    end
  end

  // A reservation in the same cycle as its writeback keeps the register busy:
  // the newer producer is still outstanding.
  assign busy_d = flush_i ? '0 : ((busy_q & ~clr_vec) | set_vec);

  always_comb begin
    dec_cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (busy_q[i] && clr_vec[i] && !set_vec[i]) begin
        dec_cnt = dec_cnt + (AW+1)'(1);
      end
    end
    inc = |(set_vec & ~busy_q);
    if (flush_i) begin
      busy_cnt_d = '0;
    end else begin
      busy_cnt_d = busy_cnt_q + (AW+1)'(inc) - dec_cnt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt_o = busy_cnt_q;

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr_i[gi*AW +: AW];

    regfile_bypass #(
      .XLEN   (XLEN),
      .AW     (AW),
      .NWRITE (NWRITE)
    ) u_bypass (
      .raddr_i  (ra),
      .we_i     (we_i),
      .waddr_i  (waddr_i),
      .wdata_i  (wdata_i),
      .stored_i (regs_q[ra]),
      .busy_i   (busy_q[ra]),
      .rdata_o  (rdata_o[gi*XLEN +: XLEN]),
      .rbusy_o  (rbusy_o[gi])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized checks of regfile_sb (16 regs, 3 read, 2 write ports)
// against an array/scoreboard reference model.
module tb_regfile_sb;

  localparam int XLEN   = 32;
  localparam int NREGS  = 16;
  localparam int NREAD  = 3;
  localparam int NWRITE = 2;
  localparam int AW     = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NWRITE-1:0]      we;
  logic [NWRITE*AW-1:0]   waddr;
  logic [NWRITE*XLEN-1:0] wdata;
  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*XLEN-1:0]  rdata;
  logic [NREAD-1:0]       rbusy;
  logic                   issue_valid;
  logic [AW-1:0]          issue_rd;
  logic                   flush;
  logic [AW:0]            busy_cnt;

  int nchecks = 0;
  int nerr    = 0;

  logic [31:0] m_mem  [NREGS];
  bit          m_busy [NREGS];

  regfile_sb #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .NWRITE (NWRITE)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .we_i          (we),
    .waddr_i       (waddr),
    .wdata_i       (wdata),
    .raddr_i       (raddr),
    .rdata_o       (rdata),
    .rbusy_o       (rbusy),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .flush_i       (flush),
    .busy_cnt_o    (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nchecks++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Reference: what a reader of register ra sees this cycle.
  function automatic logic [31:0] m_rdata(input logic [AW-1:0] ra);
    logic [31:0] v;
    if (ra == 0) return 32'd0;
    v = m_mem[ra];
    for (int k = 0; k < NWRITE; k++)
      if (we[k] && waddr[k*AW +: AW] == ra) v = wdata[k*XLEN +: XLEN];
    return v;
  endfunction

  function automatic bit m_rbusy(input logic [AW-1:0] ra);
    if (ra == 0) return 1'b0;
    for (int k = 0; k < NWRITE; k++)
      if (we[k] && waddr[k*AW +: AW] == ra) return 1'b0;
    return m_busy[ra];
  endfunction

  function automatic int m_pop();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_mem[i]  = 32'd0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic m_edge();
    logic [AW-1:0] a;
    for (int k = 0; k < NWRITE; k++) begin
      a = waddr[k*AW +: AW];
      if (we[k] && a != 0) m_mem[a] = wdata[k*XLEN +: XLEN];
    end
    if (flush) begin
      for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    end else begin
      for (int k = 0; k < NWRITE; k++) begin
        a = waddr[k*AW +: AW];
        if (we[k] && a != 0) m_busy[a] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
  endtask

  task automatic drive_idle();
    we          = '0;
    waddr       = '0;
    wdata       = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    flush       = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
    we[p]                = 1'b1;
    waddr[p*AW +: AW]    = a;
    wdata[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    issue_valid = 1'b1;
    issue_rd    = a;
  endtask

  task automatic check_comb();
    logic [AW-1:0] ra;
    for (int j = 0; j < NREAD; j++) begin
      ra = raddr[j*AW +: AW];
      chk($sformatf("rdata%0d(x%0d)", j, ra), rdata[j*XLEN +: XLEN], m_rdata(ra));
      chk($sformatf("rbusy%0d(x%0d)", j, ra), 32'(rbusy[j]), 32'(m_rbusy(ra)));
    end
  endtask

  // One clock: check bypassed outputs before the edge, advance the model,
  // then check the registered count at the following falling edge.
  task automatic cycle();
    #1 check_comb();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    chk("busy_cnt", 32'(busy_cnt), 32'(m_pop()));
    drive_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    raddr = '0;
    m_reset();
    #2 rst = 1'b1;
    #1;
    chk("reset_cnt", 32'(busy_cnt), 32'd0);
    chk("reset_rdata0", rdata[31:0], 32'd0);
    chk("reset_rbusy", 32'(rbusy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Same-cycle bypass, then stored value
    wr(0, 4'd7, 32'h1234); rd(0, 4'd7);
    #1 chk("bypass_x7", rdata[31:0], 32'h1234);
    cycle();
    #1 chk("stored_x7", rdata[31:0], 32'h1234);

    // x0 is hardwired to zero
    wr(0, 4'd0, 32'hFFFF); rd(0, 4'd0);
    cycle();
    #1 chk("x0_zero", rdata[31:0], 32'd0);

    // Dual-port conflict: port 1 wins
    wr(0, 4'd3, 32'hA); wr(1, 4'd3, 32'hB); rd(1, 4'd3);
    #1 chk("dual_bypass", rdata[63:32], 32'hB);
    cycle();
    #1 chk("dual_stored", rdata[63:32], 32'hB);

    // Scoreboard set and writeback clear
    issue(4'd9); rd(2, 4'd9);
    cycle();
    #1 chk("x9_busy", 32'(rbusy[2]), 32'd1);
    chk("cnt_issue", 32'(busy_cnt), 32'd1);
    wr(0, 4'd9, 32'h99);
    #1 chk("x9_wb_rbusy", 32'(rbusy[2]), 32'd0);
    cycle();
    chk("cnt_wb", 32'(busy_cnt), 32'd0);

    // Issue and write the same register in one cycle: stays busy
    issue(4'd9);
    cycle();
    issue(4'd9); wr(1, 4'd9, 32'h55);
    cycle();
    #1 chk("x9_still_busy", 32'(rbusy[2]), 32'd1);
    chk("cnt_same", 32'(busy_cnt), 32'd1);
    chk("x9_data", rdata[95:64], 32'h55);
    wr(0, 4'd9, 32'h0);
    cycle();

    // Flush beats a same-cycle issue
    issue(4'd1); cycle();
    issue(4'd2); cycle();
    issue(4'd3); cycle();
    chk("cnt_three", 32'(busy_cnt), 32'd3);
    flush = 1'b1; issue(4'd4); rd(0, 4'd4);
    cycle();
    chk("cnt_flush", 32'(busy_cnt), 32'd0);
    #1 chk("x4_not_busy", 32'(rbusy[0]), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NWRITE; k++)
        if ($urandom_range(0, 2) == 0) wr(k, AW'($urandom_range(0, NREGS-1)), $urandom);
      for (int j = 0; j < NREAD; j++) begin
        if ($urandom_range(0, 3) == 0) rd(j, waddr[AW-1:0]);
        else rd(j, AW'($urandom_range(0, NREGS-1)));
      end
      if ($urandom_range(0, 1) == 0) issue(AW'($urandom_range(0, NREGS-1)));
      flush = ($urandom_range(0, 24) == 0);
      cycle();
    end

    // Asynchronous reset between edges
    wr(0, 4'd5, 32'hDEADBEEF); issue(4'd6);
    cycle();
    rd(0, 4'd5); rd(1, 4'd6);
    #1 chk("pre_rst_x5", rdata[31:0], 32'hDEADBEEF);
    chk("pre_rst_x6_busy", 32'(rbusy[1]), 32'd1);
    #1 rst = 1'b1;
    m_reset();
    #1;
    chk("rst_x5", rdata[31:0], 32'd0);
    chk("rst_rbusy", 32'(rbusy), 32'd0);
    chk("rst_cnt", 32'(busy_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
